// File: rtl/sprite_scheduler.sv
// ============================================================================
// sprite_scheduler: double-buffered player/bomb placement with per-pixel hit
// test and sprite-RAM addressing.  Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_scheduler #(
  parameter int PLAYER_BASE = 0,
  parameter int PLAYER_W    = 32,
  parameter int PLAYER_H    = 32,
  parameter int BOMB_BASE   = 1024,
  parameter int BOMB_W      = 16,
  parameter int BOMB_H      = 16,
  parameter int BOMB_FRAMES = 2,
  parameter int BOMB_DIV    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_sel,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic        wr_en,
  output logic        drawPlayer,
  output logic        drawBomb,
  output logic [10:0] addrPlayer,
  output logic [10:0] addrBomb
);

  localparam int FRAME_W = (BOMB_FRAMES > 1) ? $clog2(BOMB_FRAMES) : 1;
  localparam int DIV_W   = (BOMB_DIV > 1) ? $clog2(BOMB_DIV) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BOMB_FRAMES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(BOMB_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } obj_t;

  state_t             state_q, state_d;
  obj_t               p_shadow_q, p_shadow_d, b_shadow_q, b_shadow_d;
  obj_t               p_active_q, p_active_d, b_active_q, b_active_d;
  logic [FRAME_W-1:0] bomb_frame_q, bomb_frame_d;
  logic [DIV_W-1:0]   bomb_div_q, bomb_div_d;
  logic               draw_player_q, draw_player_d, draw_bomb_q, draw_bomb_d;
  logic [10:0]        addr_player_q, addr_player_d, addr_bomb_q, addr_bomb_d;

  logic        wr_fire, on_screen, p_hit, b_hit;
  logic [10:0] dx, dy, px, py, bx, by;
  logic [10:0] p_off_x, p_off_y, b_off_x, b_off_y;

  assign wr_ready = (state_q != COMMIT);
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = COMMIT;
      SCAN:    if (frame_start) state_d = COMMIT;
      COMMIT:  state_d = SCAN;
      default: state_d = IDLE;
    endcase
  end

  // Shadow registers take host writes; active registers only move in COMMIT.
  always_comb begin
    p_shadow_d   = p_shadow_q;
    b_shadow_d   = b_shadow_q;
    p_active_d   = p_active_q;
    b_active_d   = b_active_q;
    bomb_frame_d = bomb_frame_q;
    bomb_div_d   = bomb_div_q;
    if (wr_fire) begin
      if (wr_sel) b_shadow_d = '{x: wr_x, y: wr_y, en: wr_en};
      else        p_shadow_d = '{x: wr_x, y: wr_y, en: wr_en};
    end
    if (state_q == COMMIT) begin
      p_active_d = p_shadow_q;
      b_active_d = b_shadow_q;
      // A bomb that is newly shown (or hidden) restarts its animation.
      if (!b_shadow_q.en || !b_active_q.en) begin
        bomb_frame_d = '0;
        bomb_div_d   = '0;
      end else if (bomb_div_q == DIV_LAST) begin
        bomb_div_d   = '0;
        bomb_frame_d = (bomb_frame_q == FRAME_LAST) ? '0 : bomb_frame_q + 1'b1;
      end else begin
        bomb_div_d   = bomb_div_q + 1'b1;
      end
    end
  end

  // Everything at 11 bits so that an object hanging past the right/bottom
  // edge cannot wrap around onto column/row 0.
  always_comb begin
    dx        = {1'b0, DrawX};
    dy        = {1'b0, DrawY};
    px        = {1'b0, p_active_q.x};
    py        = {1'b0, p_active_q.y};
    bx        = {1'b0, b_active_q.x};
    by        = {1'b0, b_active_q.y};
    on_screen = (dx < 11'd640) && (dy < 11'd480);
    p_hit     = p_active_q.en && on_screen &&
                (dx >= px) && (dx <= px + 11'(PLAYER_W - 1)) &&
                (dy >= py) && (dy <= py + 11'(PLAYER_H - 1));
    b_hit     = b_active_q.en && on_screen &&
                (dx >= bx) && (dx <= bx + 11'(BOMB_W - 1)) &&
                (dy >= by) && (dy <= by + 11'(BOMB_H - 1));
    p_off_x   = dx - px;
    p_off_y   = dy - py;
    b_off_x   = dx - bx;
    b_off_y   = dy - by;

    draw_player_d = 1'b0;
    draw_bomb_d   = 1'b0;
    addr_player_d = '0;
    addr_bomb_d   = '0;
    if (state_q == SCAN) begin
      draw_player_d = p_hit;
      draw_bomb_d   = b_hit;
      if (p_hit) addr_player_d = 11'(PLAYER_BASE) + p_off_y * 11'(PLAYER_W) + p_off_x;
      if (b_hit) addr_bomb_d   = 11'(BOMB_BASE) + 11'(bomb_frame_q) * 11'(BOMB_W * BOMB_H)
                                 + b_off_y * 11'(BOMB_W) + b_off_x;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      p_shadow_q    <= '0;
      b_shadow_q    <= '0;
      p_active_q    <= '0;
      b_active_q    <= '0;
      bomb_frame_q  <= '0;
      bomb_div_q    <= '0;
      draw_player_q <= 1'b0;
      draw_bomb_q   <= 1'b0;
      addr_player_q <= '0;
      addr_bomb_q   <= '0;
    end else begin
      state_q       <= state_d;
      p_shadow_q    <= p_shadow_d;
      b_shadow_q    <= b_shadow_d;
      p_active_q    <= p_active_d;
      b_active_q    <= b_active_d;
      bomb_frame_q  <= bomb_frame_d;
      bomb_div_q    <= bomb_div_d;
      draw_player_q <= draw_player_d;
      draw_bomb_q   <= draw_bomb_d;
      addr_player_q <= addr_player_d;
      addr_bomb_q   <= addr_bomb_d;
    end
  end

  assign drawPlayer = draw_player_q;
  assign drawBomb   = draw_bomb_q;
  assign addrPlayer = addr_player_q;
  assign addrBomb   = addr_bomb_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_scheduler.sv
// ============================================================================
// tb_sprite_scheduler: directed self-checking bench for sprite_scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sprite_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  DrawX = 10'd1023;
  logic [9:0]  DrawY = 10'd1023;
  logic        frame_start = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        wr_sel = 1'b0;
  logic [9:0]  wr_x = '0;
  logic [9:0]  wr_y = '0;
  logic        wr_en = 1'b0;
  logic        drawPlayer, drawBomb;
  logic [10:0] addrPlayer, addrBomb;

  int n_vec = 0;
  int n_err = 0;

  sprite_scheduler dut (
    .clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_x(wr_x), .wr_y(wr_y), .wr_en(wr_en),
    .drawPlayer(drawPlayer), .drawBomb(drawBomb),
    .addrPlayer(addrPlayer), .addrBomb(addrBomb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic sel, input int x, input int y, input logic en);
    wr_valid = 1'b1; wr_sel = sel; wr_x = 10'(x); wr_y = 10'(y); wr_en = en;
    tick();
    wr_valid = 1'b0;
  endtask

  // frame_start cycle then the COMMIT cycle; returns in the first SCAN cycle
  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic probe(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y);
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_vec++; if (drawPlayer !== 1'b0) begin n_err++; $display("FAIL reset_drawPlayer got %0b want 0", drawPlayer); end
    n_vec++; if (drawBomb !== 1'b0) begin n_err++; $display("FAIL reset_drawBomb got %0b want 0", drawBomb); end
    n_vec++; if (addrPlayer !== 11'd0) begin n_err++; $display("FAIL reset_addrPlayer got %0d want 0", addrPlayer); end
    n_vec++; if (addrBomb !== 11'd0) begin n_err++; $display("FAIL reset_addrBomb got %0d want 0", addrBomb); end
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %0b want 1", wr_ready); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_shadow_only();
    do_write(1'b0, 100, 50, 1'b1);
    do_write(1'b0, 200, 60, 1'b1);
    do_write(1'b1, 10, 10, 1'b1);
    probe(100, 50);
    n_vec++; if (drawPlayer !== 1'b0) begin n_err++; $display("FAIL shadow_p1 got %0b want 0", drawPlayer); end
    probe(200, 60);
    n_vec++; if (drawPlayer !== 1'b0) begin n_err++; $display("FAIL shadow_p2 got %0b want 0", drawPlayer); end
    probe(10, 10);
    n_vec++; if (drawBomb !== 1'b0) begin n_err++; $display("FAIL shadow_b got %0b want 0", drawBomb); end
    do_frame();
    probe(100, 50);
    n_vec++; if (drawPlayer !== 1'b0) begin n_err++; $display("FAIL shadow_replaced got %0b want 0", drawPlayer); end
    probe(200, 60);
    n_vec++; if (drawPlayer !== 1'b1 || addrPlayer !== 11'd0) begin n_err++;
      $display("FAIL shadow_second got draw=%0b addr=%0d want draw=1 addr=0", drawPlayer, addrPlayer); end
    probe(10, 10);
    n_vec++; if (drawBomb !== 1'b1 || addrBomb !== 11'd1024) begin n_err++;
      $display("FAIL shadow_bomb got draw=%0b addr=%0d want draw=1 addr=1024", drawBomb, addrBomb); end
  endtask

  task automatic test_commit_timing();
    do_write(1'b0, 100, 50, 1'b1);
    do_frame();
    probe(100, 50);
    n_vec++; if (drawPlayer !== 1'b1 || addrPlayer !== 11'd0) begin n_err++;
      $display("FAIL commit_origin got draw=%0b addr=%0d want draw=1 addr=0", drawPlayer, addrPlayer); end
    probe(131, 81);
    n_vec++; if (drawPlayer !== 1'b1 || addrPlayer !== 11'd1023) begin n_err++;
      $display("FAIL commit_corner got draw=%0b addr=%0d want draw=1 addr=1023", drawPlayer, addrPlayer); end
    probe(132, 81);
    n_vec++; if (drawPlayer !== 1'b0 || addrPlayer !== 11'd0) begin n_err++;
      $display("FAIL commit_outside got draw=%0b addr=%0d want draw=0 addr=0", drawPlayer, addrPlayer); end
  endtask

  task automatic test_write_in_commit();
    wr_valid = 1'b1; wr_sel = 1'b0; wr_x = 10'd300; wr_y = 10'd200; wr_en = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wr_x = 10'd400;
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL commit_ready got %0b want 0", wr_ready); end
    tick();
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL scan_ready got %0b want 1", wr_ready); end
    wr_valid = 1'b0;
    probe(300, 200);
    n_vec++; if (drawPlayer !== 1'b1 || addrPlayer !== 11'd0) begin n_err++;
      $display("FAIL wic_included got draw=%0b addr=%0d want draw=1 addr=0", drawPlayer, addrPlayer); end
    do_frame();
    probe(300, 200);
    n_vec++; if (drawPlayer !== 1'b1) begin n_err++; $display("FAIL wic_kept got %0b want 1", drawPlayer); end
    probe(400, 200);
    n_vec++; if (drawPlayer !== 1'b0) begin n_err++; $display("FAIL wic_dropped got %0b want 0", drawPlayer); end
  endtask

  task automatic test_screen_edge();
    do_write(1'b1, 0, 0, 1'b0);
    do_frame();
    do_write(1'b1, 630, 470, 1'b1);
    do_frame();
    probe(639, 479);
    n_vec++; if (drawBomb !== 1'b1 || addrBomb !== 11'd1177) begin n_err++;
      $display("FAIL edge_corner got draw=%0b addr=%0d want draw=1 addr=1177", drawBomb, addrBomb); end
    probe(0, 0);
    n_vec++; if (drawBomb !== 1'b0 || addrBomb !== 11'd0) begin n_err++;
      $display("FAIL edge_nowrap got draw=%0b addr=%0d want draw=0 addr=0", drawBomb, addrBomb); end
    probe(640, 479);
    n_vec++; if (drawBomb !== 1'b0) begin n_err++; $display("FAIL edge_offscreen got %0b want 0", drawBomb); end
  endtask

  task automatic test_animation();
    do_write(1'b1, 0, 0, 1'b0);
    do_frame();
    do_write(1'b1, 100, 100, 1'b1);
    do_frame();
    probe(100, 100);
    n_vec++; if (addrBomb !== 11'd1024) begin n_err++; $display("FAIL anim_start got %0d want 1024", addrBomb); end
    for (int i = 0; i < 7; i++) do_frame();
    probe(100, 100);
    n_vec++; if (addrBomb !== 11'd1024) begin n_err++; $display("FAIL anim_7 got %0d want 1024", addrBomb); end
    do_frame();
    probe(100, 100);
    n_vec++; if (addrBomb !== 11'd1280) begin n_err++; $display("FAIL anim_8 got %0d want 1280", addrBomb); end
    for (int i = 0; i < 8; i++) do_frame();
    probe(100, 100);
    n_vec++; if (addrBomb !== 11'd1024) begin n_err++; $display("FAIL anim_16 got %0d want 1024", addrBomb); end
    for (int i = 0; i < 8; i++) do_frame();
    do_write(1'b1, 100, 100, 1'b0);
    do_frame();
    probe(100, 100);
    n_vec++; if (drawBomb !== 1'b0) begin n_err++; $display("FAIL anim_off got %0b want 0", drawBomb); end
    do_write(1'b1, 100, 100, 1'b1);
    do_frame();
    probe(100, 100);
    n_vec++; if (drawBomb !== 1'b1 || addrBomb !== 11'd1024) begin n_err++;
      $display("FAIL anim_restart got draw=%0b addr=%0d want draw=1 addr=1024", drawBomb, addrBomb); end
  endtask

  task automatic test_overlap();
    do_write(1'b1, 310, 210, 1'b1);
    do_frame();
    probe(311, 212);
    n_vec++; if (drawPlayer !== 1'b1 || addrPlayer !== 11'd395) begin n_err++;
      $display("FAIL overlap_player got draw=%0b addr=%0d want draw=1 addr=395", drawPlayer, addrPlayer); end
    n_vec++; if (drawBomb !== 1'b1 || addrBomb !== 11'd1057) begin n_err++;
      $display("FAIL overlap_bomb got draw=%0b addr=%0d want draw=1 addr=1057", drawBomb, addrBomb); end
  endtask

  task automatic test_reset_mid_scan();
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (drawPlayer !== 1'b0 || drawBomb !== 1'b0 || addrPlayer !== 11'd0 || addrBomb !== 11'd0) begin n_err++;
      $display("FAIL rst_async got p=%0b b=%0b ap=%0d ab=%0d want all 0", drawPlayer, drawBomb, addrPlayer, addrBomb); end
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", wr_ready); end
    #1;
    reset_n = 1'b1;
    tick();
    tick();
    n_vec++; if (drawPlayer !== 1'b0 || drawBomb !== 1'b0) begin n_err++;
      $display("FAIL rst_after got p=%0b b=%0b want 0 0", drawPlayer, drawBomb); end
    do_frame();
    probe(311, 212);
    n_vec++; if (drawPlayer !== 1'b0 || drawBomb !== 1'b0) begin n_err++;
      $display("FAIL rst_empty_commit got p=%0b b=%0b want 0 0", drawPlayer, drawBomb); end
    do_write(1'b0, 500, 300, 1'b1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    do_frame();
    probe(500, 300);
    n_vec++; if (drawPlayer !== 1'b0) begin n_err++; $display("FAIL rst_commit_discard got %0b want 0", drawPlayer); end
    do_write(1'b0, 500, 300, 1'b1);
    do_frame();
    probe(501, 301);
    n_vec++; if (drawPlayer !== 1'b1 || addrPlayer !== 11'd33) begin n_err++;
      $display("FAIL rst_resume got draw=%0b addr=%0d want draw=1 addr=33", drawPlayer, addrPlayer); end
  endtask

  initial begin
    test_reset();
    test_shadow_only();
    test_commit_timing();
    test_write_in_commit();
    test_screen_edge();
    test_animation();
    test_overlap();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
